// File: rtl/lc3b_types.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc3b_types : shared LC-3b block/word types and pmem responder states |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package lc3b_types;

  typedef logic [255:0] lc3b_block;
  typedef logic [15:0]  lc3b_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

endpackage
`default_nettype wire

// File: rtl/pmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pmem_array : 2**LOG_LINES x 256-bit line store, sync read, no reset  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module pmem_array
  import lc3b_types::*;
#(
  parameter int LOG_LINES = 5
) (
  input  logic                 clk,
  input  logic                 i_rd_en,
  input  logic [LOG_LINES-1:0] i_rd_idx,
  output lc3b_block            o_rd_data,
  input  logic                 i_wr_en,
  input  logic [LOG_LINES-1:0] i_wr_idx,
  input  lc3b_block            i_wr_data
);

  lc3b_block r_mem [0:(1<<LOG_LINES)-1];
  lc3b_block r_rd_data;

  // Contents deliberately survive reset, so no reset branch here.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_idx];
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/pmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pmem_responder : fixed-latency L2-side block memory with protocol    |
// |                  violation flag                                      |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module pmem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY   = 8,
  parameter int LOG_LINES = 5
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      pmem_read,
  input  logic      pmem_write,
  input  lc3b_word  pmem_address,
  input  lc3b_block pmem_wdata,
  output lc3b_block pmem_rdata,
  output logic      pmem_resp,
  output logic      proto_err
);

  localparam int                c_CNT_W    = $clog2(LATENCY);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  pmem_state_t        r_state;
  pmem_state_t        w_next_state;
  logic [c_CNT_W-1:0] r_cnt;
  lc3b_word           r_addr;
  logic [1:0]         r_op;        // {read, write} as seen at acceptance
  lc3b_block          r_wdata;
  logic               r_rd_valid;
  logic               r_proto_err;
  lc3b_block          w_array_q;
  logic               w_accept;
  logic               w_busy_viol;
  logic               w_rd_en;
  logic               w_wr_en;
  logic [LOG_LINES-1:0] w_idx;

  assign w_accept    = (r_state == IDLE) && (pmem_read || pmem_write);
  assign w_busy_viol = (r_state == BUSY) &&
                       (({pmem_read, pmem_write} != r_op) || (pmem_address != r_addr));
  assign w_idx       = r_addr[4+LOG_LINES:5];
  assign w_rd_en     = (r_state == BUSY) && (r_cnt == c_CNT_ONE) && !r_op[0];
  assign w_wr_en     = (r_state == RESP) && r_op[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    pmem_resp    = 1'b0;
    case (r_state)
      IDLE:    if (pmem_read || pmem_write) w_next_state = BUSY;
      BUSY:    if (r_cnt == c_CNT_ONE) w_next_state = RESP;
      RESP: begin
        pmem_resp    = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_op        <= '0;
      r_wdata     <= '0;
      r_rd_valid  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= c_CNT_LOAD;
        r_addr  <= pmem_address;
        r_op    <= {pmem_read, pmem_write};
        r_wdata <= pmem_wdata;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - c_CNT_ONE;
      end
      if (w_rd_en) r_rd_valid <= 1'b1;
      if ((w_accept && pmem_read && pmem_write) || w_busy_viol) r_proto_err <= 1'b1;
    end
  end

  pmem_array #(
    .LOG_LINES (LOG_LINES)
  ) u_array (
    .clk       (clk),
    .i_rd_en   (w_rd_en),
    .i_rd_idx  (w_idx),
    .o_rd_data (w_array_q),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_idx),
    .i_wr_data (r_wdata)
  );

  // The array read register has no reset; gate it so rdata reads zero until a read lands.
  assign pmem_rdata = r_rd_valid ? w_array_q : '0;
  assign proto_err  = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_pmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pmem_responder : randomized bench with transaction-level model    |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_pmem_responder;
  import lc3b_types::*;

  localparam int LATENCY   = 8;
  localparam int LOG_LINES = 5;
  localparam int NLINES    = 1 << LOG_LINES;
  localparam int NEVER     = 32'h7fffffff;

  logic      clk = 1'b0;
  logic      reset;
  logic      pmem_read;
  logic      pmem_write;
  lc3b_word  pmem_address;
  lc3b_block pmem_wdata;
  lc3b_block pmem_rdata;
  logic      pmem_resp;
  logic      proto_err;

  pmem_responder #(
    .LATENCY   (LATENCY),
    .LOG_LINES (LOG_LINES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model: memory image, one outstanding transaction, sticky error start.
  lc3b_block mem_m [NLINES];
  int        exp_resp_cycle = -1;
  bit        exp_is_write   = 1'b0;
  int        exp_idx        = 0;
  lc3b_block exp_line       = '0;
  lc3b_block exp_rdata      = '0;
  int        err_from       = NEVER;
  int        last_resp_cycle = -1;
  int        vectors     = 0;
  int        miscompares = 0;

  task automatic chk_bit(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_blk(input string name, input lc3b_block act, input lc3b_block req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (cyc == exp_resp_cycle) begin
      if (exp_is_write) mem_m[exp_idx] = exp_line;
      else              exp_rdata = exp_line;
    end
    chk_bit("pmem_resp", pmem_resp, cyc == exp_resp_cycle);
    chk_blk("pmem_rdata", pmem_rdata, exp_rdata);
    chk_bit("proto_err", proto_err, cyc >= err_from);
    if (pmem_resp) last_resp_cycle = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input lc3b_word a);
    return int'(a[4+LOG_LINES:5]);
  endfunction

  function automatic lc3b_block rand_blk();
    lc3b_block b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Called just after a clock edge with the responder idle. viol: 1 drop, 2 address
  // change, 3 op change, applied in BUSY cycle vk; rk>0 pulls reset in cycle rk.
  task automatic txn(input bit rd, input bit wr, input lc3b_word addr, input lc3b_block data,
                     input int viol, input int vk, input int rk, output int c0);
    int c;
    c  = cyc;
    c0 = c;
    pmem_read      = rd;
    pmem_write     = wr;
    pmem_address   = addr;
    pmem_wdata     = data;
    exp_is_write   = wr;
    exp_idx        = idx_of(addr);
    exp_line       = wr ? data : mem_m[idx_of(addr)];
    exp_resp_cycle = c + LATENCY;
    if (rd && wr) err_from = min_i(err_from, c + 1);
    for (int k = 1; k <= LATENCY; k++) begin
      tick();
      if (k == rk) begin
        #1;
        reset          = 1'b0;
        exp_resp_cycle = -1;
        exp_rdata      = '0;
        err_from       = NEVER;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        return;
      end
      if (k < LATENCY && k == vk && viol != 0) begin
        case (viol)
          1: begin pmem_read = 1'b0; pmem_write = 1'b0; end
          2: pmem_address = addr ^ 16'($urandom_range(1, 65535));
          default: begin pmem_read = ~rd; pmem_write = ~wr; end
        endcase
        err_from = min_i(err_from, c + k + 1);
      end
    end
    tick();
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int        c0;
    lc3b_block line_a;
    lc3b_block line_b;
    lc3b_block line_c;
    lc3b_block pre_0080;
    reset        = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    #1 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Give every line a known value first; contents are undefined at power-up.
    for (int i = 0; i < NLINES; i++) txn(1'b0, 1'b1, 16'(i << 5), rand_blk(), 0, 0, 0, c0);
    pre_0080 = mem_m[4];

    line_a = {64{4'hA}};
    txn(1'b0, 1'b1, 16'h0040, line_a, 0, 0, 0, c0);
    chk_int("wr_latency", last_resp_cycle - c0, 8);
    txn(1'b1, 1'b0, 16'h0040, '0, 0, 0, 0, c0);
    chk_int("rd_latency", last_resp_cycle - c0, 8);
    chk_blk("rd_0040", pmem_rdata, {64{4'hA}});

    line_b = {8{32'h1234_5678}};
    txn(1'b0, 1'b1, 16'h0020, line_b, 0, 0, 0, c0);
    txn(1'b1, 1'b0, 16'h0420, '0, 0, 0, 0, c0);
    chk_blk("alias_0420", pmem_rdata, {8{32'h1234_5678}});
    txn(1'b1, 1'b0, 16'h0030, '0, 0, 0, 0, c0);
    chk_blk("offset_0030", pmem_rdata, {8{32'h1234_5678}});
    chk_bit("err_clean", proto_err, 1'b0);

    line_c = {16{16'hBEEF}};
    txn(1'b1, 1'b1, 16'h0060, line_c, 0, 0, 0, c0);
    txn(1'b1, 1'b0, 16'h0060, '0, 0, 0, 0, c0);
    chk_blk("both_0060", pmem_rdata, {16{16'hBEEF}});
    chk_bit("both_err", proto_err, 1'b1);

    txn(1'b0, 1'b1, 16'h0080, {32{8'hCC}}, 0, 0, 4, c0);
    chk_bit("rst_resp", pmem_resp, 1'b0);
    chk_blk("rst_rdata", pmem_rdata, '0);
    chk_bit("rst_err", proto_err, 1'b0);
    txn(1'b1, 1'b0, 16'h0080, '0, 0, 0, 0, c0);
    chk_blk("rst_discard", pmem_rdata, pre_0080);

    txn(1'b1, 1'b0, 16'h0040, '0, 1, 3, 0, c0);
    chk_int("drop_latency", last_resp_cycle - c0, 8);
    chk_blk("drop_data", pmem_rdata, {64{4'hA}});
    chk_bit("drop_err", proto_err, 1'b1);

    for (int n = 0; n < 200; n++) begin
      bit rd;
      bit wr;
      int viol;
      int vk;
      int rk;
      wr = 1'($urandom_range(0, 1));
      rd = !wr;
      if ($urandom_range(0, 9) == 0) begin rd = 1'b1; wr = 1'b1; end
      viol = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      vk   = int'($urandom_range(1, LATENCY - 1));
      rk   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, LATENCY)) : 0;
      txn(rd, wr, 16'($urandom), rand_blk(), viol, vk, rk, c0);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
